// File: rtl/chip8_pkg.sv
// chip8_pkg
// Shared definitions for the CHIP-8 memory subsystem.
//   - Requester ids (CPU, sprite draw engine, ROM/font loader) and their count.
//   - Arbiter state encoding.
//   - Small helpers for requester-id arithmetic and burst counting.
package chip8_pkg;

  localparam int NUM_REQ = 3;
  localparam int ID_W    = 2;
  localparam int BURST_W = 8;

  typedef logic [ID_W-1:0] req_id_t;

  localparam req_id_t REQ_CPU  = 2'd0;
  localparam req_id_t REQ_DRAW = 2'd1;
  localparam req_id_t REQ_LOAD = 2'd2;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  // Cyclic successor 0 -> 1 -> 2 -> 0; an out-of-range id folds back to CPU.
  function automatic req_id_t next_ptr(input req_id_t id);
    return (id >= REQ_LOAD) ? REQ_CPU : req_id_t'(id + 2'd1);
  endfunction

  function automatic logic [NUM_REQ-1:0] id_onehot(input req_id_t id);
    logic [NUM_REQ-1:0] oh;
    oh = '0;
    if (id <= REQ_LOAD) oh[id] = 1'b1;
    return oh;
  endfunction

  function automatic req_id_t onehot_id(input logic [NUM_REQ-1:0] oh);
    req_id_t id;
    case (oh)
      3'b010:  id = REQ_DRAW;
      3'b100:  id = REQ_LOAD;
      default: id = REQ_CPU;
    endcase
    return id;
  endfunction

  function automatic logic [BURST_W-1:0] burst_sat_inc(input logic [BURST_W-1:0] c);
    return (c == {BURST_W{1'b1}}) ? c : c + 1'b1;
  endfunction

endpackage

// File: rtl/chip8_rr_pick.sv
// chip8_rr_pick
// Combinational round-robin selector: grants the first asserted request at or
// after ptr, scanning cyclically over the requesters.
// Ports:
//   req  in  NUM_REQ  request vector
//   ptr  in  ID_W     id with highest priority this cycle
//   gnt  out NUM_REQ  one-hot grant (all zero when no request)
module chip8_rr_pick
  import chip8_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt
);

  req_id_t idx;
  logic    found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = (ptr > REQ_LOAD) ? REQ_CPU : ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
      idx = next_ptr(idx);
    end
  end

endmodule

// File: rtl/chip8_mem_arbiter.sv
// chip8_mem_arbiter
// Shares the single-port CHIP-8 RAM between the CPU (id 0), the sprite draw
// engine (id 1) and the ROM/font loader (id 2). One access per cycle,
// round-robin among requesters, with locked bursts that are bounded by
// MAX_BURST whenever someone else is waiting. Read data is returned two cycles
// after the grant, tagged to the issuing requester.
// Ports:
//   clk, reset (async, active-low)
//   req_i/lock_i/we_i   in  [2:0]           per-requester request, lock, write
//   addr_i              in  [3*ADDR_W-1:0]  requester i at [i*ADDR_W +: ADDR_W]
//   wdata_i             in  [3*DATA_W-1:0]  requester i at [i*DATA_W +: DATA_W]
//   gnt_i               out [2:0]           combinational grant
//   rvalid_i            out [2:0]           read data valid for requester i
//   rdata               out DATA_W          shared read data
//   mem_addr/mem_we/mem_wdata out           registered RAM command
//   mem_rdata           in  DATA_W          RAM read data (one cycle after address)
module chip8_mem_arbiter
  import chip8_pkg::*;
#(
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ-1:0]        lock_i,
  input  logic [NUM_REQ-1:0]        we_i,
  input  logic [NUM_REQ*ADDR_W-1:0] addr_i,
  input  logic [NUM_REQ*DATA_W-1:0] wdata_i,
  output logic [NUM_REQ-1:0]        gnt_i,
  output logic [NUM_REQ-1:0]        rvalid_i,
  output logic [DATA_W-1:0]         rdata,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic                      mem_we,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic [DATA_W-1:0]         mem_rdata
);

  localparam logic [BURST_W-1:0] BURST_LIM = BURST_W'(MAX_BURST);

  arb_state_t          state_q, state_d;
  req_id_t             owner_q, owner_d;
  req_id_t             rr_ptr_q, rr_ptr_d;
  logic [BURST_W-1:0]  burst_q, burst_d;
  logic [NUM_REQ-1:0]  pick;
  logic [NUM_REQ-1:0]  contend;
  req_id_t             pick_id;

  logic [ADDR_W-1:0]   addr_sel;
  logic [DATA_W-1:0]   wdata_sel;
  logic                we_sel;

  logic                vld_p0, vld_p1, vld_p2;
  req_id_t             id_p0, id_p1, id_p2;

  chip8_rr_pick u_pick (
    .req (req_i),
    .ptr (rr_ptr_q),
    .gnt (pick)
  );

  assign pick_id = onehot_id(pick);

  // Lock FSM and grant generation. Round-robin pointer only advances on
  // grants made from ARB_IDLE; locked accesses leave it untouched so the
  // owner does not gain extra priority after its burst.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    burst_d  = burst_q;
    gnt_i    = '0;
    contend  = req_i & ~id_onehot(owner_q);
    case (state_q)
      ARB_IDLE: begin
        gnt_i = pick;
        if (|pick) begin
          rr_ptr_d = next_ptr(pick_id);
          if (lock_i[pick_id]) begin
            state_d = ARB_LOCKED;
            owner_d = pick_id;
            burst_d = BURST_W'(1);
          end
        end
      end
      ARB_LOCKED: begin
        if ((burst_q == BURST_LIM) && (|contend)) begin
          // Forced release: owner is not served this cycle.
          state_d = ARB_IDLE;
          burst_d = '0;
        end else if (|(req_i & id_onehot(owner_q))) begin
          gnt_i   = id_onehot(owner_q);
          burst_d = burst_sat_inc(burst_q);
          if (!(|(lock_i & id_onehot(owner_q)))) begin
            state_d = ARB_IDLE;
            burst_d = '0;
          end
        end else if (!(|(lock_i & id_onehot(owner_q)))) begin
          state_d = ARB_IDLE;
          burst_d = '0;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    addr_sel  = '0;
    wdata_sel = '0;
    we_sel    = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (gnt_i[k]) begin
        addr_sel  = addr_i[k*ADDR_W +: ADDR_W];
        wdata_sel = wdata_i[k*DATA_W +: DATA_W];
        we_sel    = we_i[k];
      end
    end
  end

  assign vld_p0 = (|gnt_i) & ~we_sel;
  assign id_p0  = onehot_id(gnt_i);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ARB_IDLE;
      owner_q  <= REQ_CPU;
      rr_ptr_q <= REQ_CPU;
      burst_q  <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      burst_q  <= burst_d;
    end
  end

  // Stage p0 -> p1: granted access drives the RAM; read tag enters pipeline.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      vld_p1    <= 1'b0;
      id_p1     <= REQ_CPU;
    end else begin
      if (|gnt_i) begin
        mem_addr  <= addr_sel;
        mem_we    <= we_sel;
        mem_wdata <= wdata_sel;
      end else begin
        mem_we    <= 1'b0;
      end
      vld_p1 <= vld_p0;
      id_p1  <= id_p0;
    end
  end

  // Stage p1 -> p2: RAM samples the address; its output is valid during p2.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p2 <= 1'b0;
      id_p2  <= REQ_CPU;
    end else begin
      vld_p2 <= vld_p1;
      id_p2  <= id_p1;
    end
  end

  assign rvalid_i = vld_p2 ? id_onehot(id_p2) : '0;
  assign rdata    = vld_p2 ? mem_rdata : '0;

endmodule

// File: tb/tb_chip8_mem_arbiter.sv
module tb_chip8_mem_arbiter;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 8;

  logic              clk;
  logic              reset;
  logic [2:0]        req, lock, we;
  logic [ADDR_W-1:0] addr  [3];
  logic [DATA_W-1:0] wdata [3];
  logic [3*ADDR_W-1:0] addr_bus;
  logic [3*DATA_W-1:0] wdata_bus;
  logic [2:0]        gnt, rvalid;
  logic [DATA_W-1:0] rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  assign addr_bus  = {addr[2], addr[1], addr[0]};
  assign wdata_bus = {wdata[2], wdata[1], wdata[0]};

  chip8_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_i     (req),
    .lock_i    (lock),
    .we_i      (we),
    .addr_i    (addr_bus),
    .wdata_i   (wdata_bus),
    .gnt_i     (gnt),
    .rvalid_i  (rvalid),
    .rdata     (rdata),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM model, preloaded with ram[a] = a[7:0].
  logic [DATA_W-1:0] ram [4096];
  initial begin
    for (int i = 0; i < 4096; i++) ram[i] = i[7:0];
    mem_rdata = '0;
  end
  always @(posedge clk) begin
    mem_rdata <= ram[mem_addr];
    if (mem_we) ram[mem_addr] = mem_wdata;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0] id;
    logic [7:0] data;
    int         due;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected RAM command for the cycle after the previous tick.
  logic              pm_valid = 1'b0;
  logic              pm_we    = 1'b0;
  logic [ADDR_W-1:0] pm_addr  = '0;
  logic [DATA_W-1:0] pm_wdata = '0;

  task automatic tick(input logic [2:0] eg, input logic [7:0] erd);
    int   idx;
    exp_t e;
    @(negedge clk);
    chk("mem_we", mem_we, pm_we);
    if (pm_valid) begin
      chk("mem_addr", mem_addr, pm_addr);
      if (pm_we) chk("mem_wdata", mem_wdata, pm_wdata);
    end
    chk("gnt", gnt, eg);
    idx = 0;
    for (int k = 0; k < 3; k++) if (eg[k]) idx = k;
    pm_valid = (eg != 3'b000);
    pm_we    = pm_valid && we[idx];
    pm_addr  = addr[idx];
    pm_wdata = wdata[idx];
    if (pm_valid && !we[idx]) begin
      e.id   = idx[1:0];
      e.data = erd;
      e.due  = cyc + 2;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops the scoreboard whenever the DUT returns read data.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0 && sb[0].due < cyc) begin
      e = sb.pop_front();
      checks++;
      errors++;
      $display("FAIL rvalid_missing: id %0d due cycle %0d not returned (now %0d)", e.id, e.due, cyc);
    end
    if (rvalid !== 3'b000) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rvalid_unexpected: got rvalid 0x%0h rdata 0x%0h expected none", rvalid, rdata);
      end else begin
        e = sb.pop_front();
        checks++;
        if (rvalid !== (3'b001 << e.id) || rdata !== e.data || cyc != e.due) begin
          errors++;
          $display("FAIL rvalid: got rvalid 0x%0h rdata 0x%0h cycle %0d expected rvalid 0x%0h rdata 0x%0h cycle %0d",
                   rvalid, rdata, cyc, 3'b001 << e.id, e.data, e.due);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0;
    req = '0; lock = '0; we = '0;
    for (int i = 0; i < 3; i++) begin addr[i] = '0; wdata[i] = '0; end
    #3;
    chk("rst_gnt", gnt, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // All three requesting, unlocked: strict rotation 0,1,2,0,1,2.
    req = 3'b111;
    addr[0] = 12'h010; addr[1] = 12'h021; addr[2] = 12'h032;
    repeat (2) begin
      tick(3'b001, 8'h10);
      tick(3'b010, 8'h21);
      tick(3'b100, 8'h32);
    end

    // Write then read of the same address by different requesters.
    req = 3'b001; we = 3'b001; addr[0] = 12'h300; wdata[0] = 8'h5A;
    tick(3'b001, 8'h00);
    req = 3'b010; we = 3'b000; addr[1] = 12'h300;
    tick(3'b010, 8'h5A);
    req = 3'b000;
    tick(3'b000, 8'h00);

    // Loader locked write burst; CPU starts waiting at the 5th access.
    req = 3'b100; lock = 3'b100; we = 3'b100;
    for (int k = 0; k < 16; k++) begin
      addr[2]  = ADDR_W'(k);
      wdata[2] = 8'h80 + 8'(k);
      if (k == 4) begin req[0] = 1'b1; addr[0] = 12'h001; end
      tick(3'b100, 8'h00);
    end
    addr[2] = 12'h010; wdata[2] = 8'h90;
    tick(3'b000, 8'h00);
    tick(3'b001, 8'h81);
    req[0] = 1'b0;
    for (int k = 16; k < 20; k++) begin
      addr[2]  = ADDR_W'(k);
      wdata[2] = 8'h80 + 8'(k);
      lock[2]  = (k != 19);
      tick(3'b100, 8'h00);
    end
    req = 3'b000; lock = 3'b000; we = 3'b000;
    req = 3'b001; addr[0] = 12'h013;
    tick(3'b001, 8'h93);

    // CPU locked 3-read burst with draw engine pending.
    req = 3'b010; addr[1] = 12'h300;
    tick(3'b010, 8'h5A);
    req = 3'b011; lock = 3'b001; addr[0] = 12'h200; addr[1] = 12'h3FF;
    tick(3'b001, 8'h00);
    addr[0] = 12'h201;
    tick(3'b001, 8'h01);
    addr[0] = 12'h202; lock = 3'b000;
    tick(3'b001, 8'h02);
    req = 3'b010;
    tick(3'b010, 8'hFF);
    req = 3'b000;

    // Reset asserted one cycle after a read grant: the read never returns.
    req = 3'b001; addr[0] = 12'h0AB;
    tick(3'b001, 8'hAB);
    req = 3'b000;
    #2 reset = 1'b0;
    sb.delete();
    pm_valid = 1'b0; pm_we = 1'b0;
    #1;
    chk("arst_mem_addr", mem_addr, 0);
    chk("arst_mem_we", mem_we, 0);
    chk("arst_rvalid", rvalid, 0);
    chk("arst_rdata", rdata, 0);
    chk("arst_gnt", gnt, 0);
    @(posedge clk);
    #1 reset = 1'b1;
    tick(3'b000, 8'h00);
    tick(3'b000, 8'h00);

    // Single requester alternating write/read, then idle.
    req = 3'b001; addr[0] = 12'h400; wdata[0] = 8'h11; we = 3'b001;
    tick(3'b001, 8'h00);
    we = 3'b000;
    tick(3'b001, 8'h11);
    addr[0] = 12'h401; wdata[0] = 8'h22; we = 3'b001;
    tick(3'b001, 8'h00);
    we = 3'b000;
    tick(3'b001, 8'h22);
    req = 3'b000;
    repeat (4) tick(3'b000, 8'h00);

    chk("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
